// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, channel constants and lowest-set-bit helper for the scan sequencer.
package scan_pkg;
    localparam int N_CH = 8;
    localparam int CH_W = $clog2(N_CH);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, BLANK = 2'd2} state_t;
    function automatic logic [CH_W-1:0] first_set(input logic [N_CH-1:0] m);
        first_set = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (m[i]) first_set = CH_W'(i);
    endfunction
endpackage

// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: control/config inputs and decoder-drive outputs of the scan sequencer.
interface scan_sequencer_if import scan_pkg::*; #(
    parameter int DWELL_W = 8,
    parameter int BLANK_W = 4
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [N_CH-1:0]    mask;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank;
    logic [CH_W-1:0]    sel;
    logic               sel_en;
    logic               busy;
    logic               done;
    logic               sweep_done;
    modport master (
        output start, stop, cont, mask, dwell, blank,
        input  sel, sel_en, busy, done, sweep_done
    );
    modport slave (
        input  start, stop, cont, mask, dwell, blank,
        output sel, sel_en, busy, done, sweep_done
    );
endinterface

// File: rtl/chan_pick.sv
// chan_pick: circular search for the next set mask bit strictly above the current channel.
module chan_pick import scan_pkg::*; (
    input  logic [N_CH-1:0] i_mask,
    input  logic [CH_W-1:0] i_cur,
    output logic [CH_W-1:0] o_next,
    output logic            o_wrap
);
    logic [CH_W-1:0] w_idx;
    // Descending offsets so the nearest set bit above the current one wins.
    always_comb begin
        o_next = i_cur;
        w_idx  = '0;
        for (int i = N_CH - 1; i >= 1; i--) begin
            w_idx = i_cur + CH_W'(i);
            if (i_mask[w_idx]) o_next = w_idx;
        end
        o_wrap = o_next <= i_cur;
    end
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: sweeps enabled channels of a 3-to-8 decoder with per-channel dwell and inter-channel blanking.
module scan_sequencer import scan_pkg::*; #(
    parameter int DWELL_W = 8,
    parameter int BLANK_W = 4
) (
    input logic             clk,
    input logic             rst,
    scan_sequencer_if.slave bus
);
    state_t             r_state;
    logic               r_cont;
    logic [N_CH-1:0]    r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [BLANK_W-1:0] r_blank;
    logic [BLANK_W-1:0] r_bcnt;
    logic [CH_W-1:0]    r_sel;
    logic               r_sel_en;
    logic               r_busy;
    logic               r_done;
    logic               r_sweep_done;
    logic [CH_W-1:0]    w_next;
    logic               w_wrap;
    logic               w_dwell_end;
    logic               w_blank_end;
    chan_pick u_pick (
        .i_mask (r_mask),
        .i_cur  (r_sel),
        .o_next (w_next),
        .o_wrap (w_wrap)
    );
    // A loaded count of 0 or 1 both mean this is the final cycle, so dwell=0 acts as 1.
    assign w_dwell_end = r_cnt <= DWELL_W'(1);
    assign w_blank_end = r_bcnt <= BLANK_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cont       <= 1'b0;
            r_mask       <= '0;
            r_dwell      <= '0;
            r_cnt        <= '0;
            r_blank      <= '0;
            r_bcnt       <= '0;
            r_sel        <= '0;
            r_sel_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_sweep_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.stop && |bus.mask) begin
                        r_cont   <= bus.cont;
                        r_mask   <= bus.mask;
                        r_dwell  <= bus.dwell;
                        r_blank  <= bus.blank;
                        r_cnt    <= bus.dwell;
                        r_sel    <= first_set(bus.mask);
                        r_sel_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.stop) begin
                        r_state  <= IDLE;
                        r_sel_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_dwell_end) begin
                        r_sweep_done <= w_wrap;
                        if (w_wrap && !r_cont) begin
                            r_state  <= IDLE;
                            r_done   <= 1'b1;
                            r_sel_en <= 1'b0;
                            r_busy   <= 1'b0;
                        end else if (r_blank != '0) begin
                            r_state  <= BLANK;
                            r_sel_en <= 1'b0;
                            r_bcnt   <= r_blank;
                        end else begin
                            r_sel <= w_next;
                            r_cnt <= r_dwell;
                        end
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end
                BLANK: begin
                    if (bus.stop) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                    end else if (w_blank_end) begin
                        r_state  <= ACTIVE;
                        r_sel    <= w_next;
                        r_sel_en <= 1'b1;
                        r_cnt    <= r_dwell;
                    end else begin
                        r_bcnt <= r_bcnt - BLANK_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.sel        = r_sel;
    assign bus.sel_en     = r_sel_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sweep_done = r_sweep_done;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: table-driven directed checks of scan_sequencer plus multi-cycle sweep sequences.
module tb_scan_sequencer;
    typedef struct packed {
        logic       rst, start, stop, cont;
        logic [7:0] mask, dwell;
        logic [3:0] blank;
        logic [2:0] sel;
        logic       en, busy, done, sd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    scan_sequencer_if #(.DWELL_W(8), .BLANK_W(4)) bus();
    scan_sequencer #(.DWELL_W(8), .BLANK_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic vec_t mk(logic r, logic s, logic p, logic c, logic [7:0] m, logic [7:0] d,
                                logic [3:0] b, logic [2:0] sl, logic e, logic bz, logic dn, logic sd);
        mk = '{r, s, p, c, m, d, b, sl, e, bz, dn, sd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(string nm, logic [2:0] sl, logic e, logic bz, logic dn, logic sd);
        chk({nm, ".sel"}, 8'(bus.sel), 8'(sl));
        chk({nm, ".sel_en"}, 8'(bus.sel_en), 8'(e));
        chk({nm, ".busy"}, 8'(bus.busy), 8'(bz));
        chk({nm, ".done"}, 8'(bus.done), 8'(dn));
        chk({nm, ".sweep_done"}, 8'(bus.sweep_done), 8'(sd));
    endtask

    task automatic drive(logic s, logic p, logic c, logic [7:0] m, logic [7:0] d, logic [3:0] b);
        bus.start = s;
        bus.stop  = p;
        bus.cont  = c;
        bus.mask  = m;
        bus.dwell = d;
        bus.blank = b;
    endtask

    initial begin
        drive(0, 0, 0, 8'h00, 8'd0, 4'd0);
        // reset, ignored starts/stops, dwell=0 single channel
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'hFF, 3, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'hFF, 3, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h01, 0, 3,  0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h01, 0, 3,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'h01, 0, 3,  0, 0, 0, 0, 0));
        // continuous, no blank, mask A4; busy start ignored; stop on dwell expiry
        tbl.push_back(mk(0, 1, 0, 1, 8'hA4, 1, 0,  2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hA4, 1, 0,  5, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hA4, 1, 0,  7, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hA4, 1, 0,  2, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'hA4, 1, 0,  5, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h01, 1, 0,  7, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h01, 1, 0,  7, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h01, 1, 0,  7, 0, 0, 0, 0));
        // continuous with blank=2, reset mid-blank, then fresh single sweep
        tbl.push_back(mk(0, 1, 0, 1, 8'h03, 1, 2,  0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 1, 2,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 1, 2,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 1, 2,  1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h03, 1, 2,  1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 8'h03, 1, 2,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h0C, 1, 0,  2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h0C, 1, 0,  3, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h0C, 1, 0,  3, 0, 0, 1, 1));
        step();
        step();
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].start, tbl[i].stop, tbl[i].cont, tbl[i].mask, tbl[i].dwell, tbl[i].blank);
            step();
            chk_all($sformatf("row%0d", i), tbl[i].sel, tbl[i].en, tbl[i].busy, tbl[i].done, tbl[i].sd);
        end
        rst = 1'b0;
        // full FF sweep, dwell 2 blank 1, with config churn and a busy start mid-sweep
        drive(1, 0, 0, 8'hFF, 8'd2, 4'd1);
        step();
        drive(0, 0, 0, 8'hFF, 8'd2, 4'd1);
        for (int c = 1; c <= 24; c++) begin
            chk_all($sformatf("ff_c%0d", c), (c < 24) ? 3'((c - 1) / 3) : 3'd7,
                    (c < 24) && ((c - 1) % 3 != 2), c < 24, c == 24, c == 24);
            if (c == 5) drive(1, 0, 1, 8'h01, 8'd9, 4'd0);
            if (c == 6) drive(0, 0, 1, 8'h81, 8'd0, 4'd7);
            if (c < 24) step();
        end
        // stop on third active cycle of channel 3
        drive(1, 0, 0, 8'hFF, 8'd5, 4'd0);
        step();
        drive(0, 0, 0, 8'hFF, 8'd5, 4'd0);
        for (int c = 1; c <= 18; c++) begin
            chk_all($sformatf("stop_c%0d", c), 3'((c - 1) / 5), 1'b1, 1'b1, 1'b0, 1'b0);
            if (c == 18) bus.stop = 1'b1;
            step();
        end
        bus.stop = 1'b0;
        chk_all("stop_after", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("stop_idle", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The module SHALL have parameter DWELL_W, default 8, meaning the width of the dwell-count input.
REQ-002 The module SHALL have parameter BLANK_W, default 4, meaning the width of the blank-count input.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a sweep; single-cycle pulse.
REQ-006 stop  input  1  abort request; single-cycle pulse.
REQ-007 cont  input  1  1 = continuous sweeping, 0 = single sweep; latched at accepted start.
REQ-008 mask  input  8  channel-enable bitmap (bit k = channel k scanned); latched at accepted start.
REQ-009 dwell  input  DWELL_W  cycles each channel is driven; latched at accepted start.
REQ-010 blank  input  BLANK_W  dead cycles between channels; latched at accepted start.
REQ-011 sel  output  3  channel index fed to the downstream 3-to-8 decoder input.
REQ-012 sel_en  output  1  decoder enable; high only while a channel is being driven.
REQ-013 busy  output  1  high while a sweep is in progress.
REQ-014 done  output  1  one-cycle pulse at the end of a single sweep.
REQ-015 sweep_done  output  1  one-cycle pulse each time the last enabled channel finishes its dwell, in either mode.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have three states: IDLE, ACTIVE and BLANK.
REQ-018 IDLE SHALL drive sel_en=0 and busy=0, and SHALL hold sel at its last value (0 after reset).
REQ-019 A start sampled in IDLE with mask!=0 SHALL be accepted: latch cont, mask, dwell and blank, and enter ACTIVE at the next edge.
REQ-020 The first ACTIVE cycle SHALL drive sel = the lowest set bit of mask, with sel_en=1 and busy=1 (start at cycle t gives sel_en=1 at t+1).
REQ-021 ACTIVE SHALL last max(dwell,1) cycles, so dwell=0 behaves as dwell=1.
REQ-022 The next channel SHALL be the next set mask bit strictly above the current channel, circularly; a wrap (next <= current, including a single-bit mask) marks end of sweep.
REQ-023 After ACTIVE with blank!=0, and not the end of a single sweep, the FSM SHALL enter BLANK for exactly blank cycles: sel_en=0, busy=1, sel holding the finished channel.
REQ-024 After ACTIVE with blank=0, sel SHALL change directly to the next channel with sel_en remaining 1 (no gap).
REQ-025 At end of sweep with cont=0: the cycle after the last dwell SHALL be IDLE, with done=1, sweep_done=1, busy=0, sel_en=0, and no trailing blank.
REQ-026 At end of sweep with cont=1: sweep_done SHALL pulse in the cycle after the last dwell (concurrent with BLANK or the next ACTIVE), and the sweep SHALL continue from the lowest set bit.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 start with mask=0 SHALL be ignored; the FSM stays in IDLE with no pulses.
REQ-029 stop sampled in ACTIVE or BLANK SHALL force IDLE at the next edge: sel_en=0, busy=0, no done and no sweep_done.
REQ-030 stop SHALL take priority over a simultaneous dwell or blank expiry; stop in IDLE SHALL be ignored.
REQ-031 start and stop asserted together in IDLE SHALL result in no sweep.
REQ-032 Changes to mask, dwell, blank or cont during a sweep SHALL have no effect until the next accepted start.

Reset
REQ-033 rst=1 SHALL at the next edge force IDLE, sel=0, sel_en=0, busy=0, done=0, sweep_done=0 and clear the counters and latched config, overriding start and stop, including mid-sweep.

Structure
REQ-034 The state encodings (IDLE=2'd0, ACTIVE=2'd1, BLANK=2'd2) and the channel count constant 8 SHALL live in the shared package scan_pkg.
REQ-035 The circular next-set-bit search SHALL be a combinational sub-module, chan_pick (inputs: mask, current index; outputs: next index, wrap flag).

Verification
REQ-036 mask=FF, dwell=2, blank=1, cont=0, start at cycle 0 -> channel k has sel_en=1 on cycles 1+3k..2+3k (k=0..7), sel_en=0 on cycles 3,6,..,21, and done=sweep_done=1 at cycle 24 with busy=0.
REQ-037 mask=8'b1010_0100, dwell=1, blank=0, cont=1 -> sel=2,5,7,2,5,7... with sel_en held high, sweep_done pulsing in each cycle where sel=2 after the first cycle, and done never asserted.
REQ-038 mask=FF, dwell=5, stop on the 3rd ACTIVE cycle of channel 3 -> next cycle sel_en=0 and busy=0, with no done.
REQ-039 rst pulsed mid-BLANK in cont mode -> all outputs 0 the next cycle; a subsequent start restarts at the lowest mask bit.
REQ-040 start with mask=0 -> nothing happens; start while busy -> ignored; dwell=0, mask=01, cont=0 -> sel_en=1 for one cycle, then done.
REQ-041 Changing mask, dwell, blank or cont mid-sweep -> the sweep sequence matches the values latched at start.
